// File: rtl/can_pkg.sv
// can_pkg: shared field widths, frame constants and FSM encoding for the CAN frame path.
package can_pkg;
    localparam int ID_W    = 11;
    localparam int DLC_W   = 4;
    localparam int FRAME_W = 108;
    localparam int CRC_W   = 15;
    localparam int HDR_LEN = 19;
    localparam int DATA_W  = 64;

    localparam logic SOF = 1'b0;
    localparam logic IDE = 1'b0;
    localparam logic R0  = 1'b0;

    localparam logic [CRC_W-1:0] CRC_POLY_DEF = 15'h4599;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_ASM  = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;
    localparam logic [2:0] S_WAIT = 3'd5;

    // Remote frames carry no data; DLC above 8 still means 8 bytes.
    function automatic logic [3:0] byte_count(input logic [DLC_W-1:0] dlc, input logic rtr);
        return rtr ? 4'd0 : (dlc > 4'd8 ? 4'd8 : dlc);
    endfunction
endpackage

// File: rtl/can_crc15.sv
// can_crc15: bit-serial CAN CRC-15 engine, one bit per enabled clock.
module can_crc15
    import can_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = CRC_POLY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);
    logic [CRC_W-1:0] r_crc;
    logic             w_nxt;

    assign w_nxt = bit_in ^ r_crc[CRC_W-1];
    assign crc   = r_crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_crc <= '0;
        else if (clr)
            r_crc <= '0;
        else if (en)
            r_crc <= {r_crc[CRC_W-2:0], 1'b0} ^ (w_nxt ? POLY : '0);
    end
endmodule

// File: rtl/can_frame_builder.sv
// can_frame_builder: collects ID/DLC/payload, runs CRC-15 serially and hands the
// 108-bit unstuffed standard frame to can_controller via tx_start/tx_ready.
module can_frame_builder
    import can_pkg::*;
#(
    parameter int               ACK_TIMEOUT = 1024,
    parameter logic [CRC_W-1:0] CRC_POLY    = CRC_POLY_DEF
) (
    input  logic               GCLK,
    input  logic               RES,
    input  logic               frame_go,
    input  logic [ID_W-1:0]    id,
    input  logic [DLC_W-1:0]   dlc,
    input  logic               rtr,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic [FRAME_W-1:0] frame_out,
    output logic               tx_start,
    input  logic               tx_ready,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    logic [2:0]       r_state;
    logic [ID_W-1:0]  r_id;
    logic [DLC_W-1:0] r_dlc;
    logic             r_rtr;
    logic [3:0]       r_n;
    logic [3:0]       r_cnt;
    logic [DATA_W-1:0] r_data;
    logic [6:0]       r_bit;
    logic [TMO_W-1:0] r_tmo;
    logic [FRAME_W-1:0] r_frame;

    logic                       w_go;
    logic                       w_xfer;
    logic                       w_tmo_hit;
    logic                       w_bit;
    logic [6:0]                 w_len;
    logic [CRC_W-1:0]           w_crc;
    logic [HDR_LEN+DATA_W-1:0]  w_hdr_data;
    logic [FRAME_W-1:0]         w_frame;

    assign w_go       = frame_go & (r_state == S_IDLE);
    assign w_xfer     = byte_valid & (r_state == S_LOAD);
    assign w_tmo_hit  = r_tmo == TMO_W'(ACK_TIMEOUT - 1);
    assign w_len      = 7'(HDR_LEN) + {r_n[3:0], 3'b000};
    assign w_hdr_data = {SOF, r_id, r_rtr, IDE, R0, r_dlc, r_data};
    assign w_bit      = w_hdr_data[7'd82 - r_bit];
    // Data is left-aligned and unused bytes stay zero, so the CRC/tail can be ORed in below it.
    assign w_frame    = {w_hdr_data, 25'h0} | ({w_crc, {(FRAME_W-CRC_W){1'b1}}} >> w_len);

    assign byte_ready = r_state == S_LOAD;
    assign tx_start   = (r_state == S_SEND) | (r_state == S_WAIT);
    assign busy       = r_state != S_IDLE;
    assign done       = (r_state == S_WAIT) & tx_ready;
    assign err        = (r_state == S_SEND) & tx_ready & w_tmo_hit;
    assign frame_out  = r_frame;

    can_crc15 #(.POLY(CRC_POLY)) u_crc (
        .clk    (GCLK),
        .rst    (RES),
        .clr    (w_go),
        .en     (r_state == S_CALC),
        .bit_in (w_bit),
        .crc    (w_crc)
    );

    always_ff @(posedge GCLK or posedge RES) begin
        if (RES) begin
            r_state <= S_IDLE;
            r_id    <= '0;
            r_dlc   <= '0;
            r_rtr   <= 1'b0;
            r_n     <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_bit   <= '0;
            r_tmo   <= '0;
            r_frame <= '1;
        end else begin
            case (r_state)
                S_IDLE: if (w_go) begin
                    r_id    <= id;
                    r_dlc   <= dlc;
                    r_rtr   <= rtr;
                    r_n     <= byte_count(dlc, rtr);
                    r_cnt   <= '0;
                    r_data  <= '0;
                    r_bit   <= '0;
                    r_state <= byte_count(dlc, rtr) == 4'd0 ? S_CALC : S_LOAD;
                end
                S_LOAD: if (w_xfer) begin
                    r_data[7'd63 - {r_cnt[2:0], 3'b000} -: 8] <= byte_in;
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == r_n - 4'd1)
                        r_state <= S_CALC;
                end
                S_CALC: begin
                    r_bit <= r_bit + 7'd1;
                    if (r_bit == w_len - 7'd1)
                        r_state <= S_ASM;
                end
                S_ASM: begin
                    r_frame <= w_frame;
                    r_tmo   <= '0;
                    r_state <= S_SEND;
                end
                // A ready that is already high must first be seen low before completion counts.
                S_SEND: begin
                    if (!tx_ready)
                        r_state <= S_WAIT;
                    else if (w_tmo_hit)
                        r_state <= S_IDLE;
                    else
                        r_tmo <= r_tmo + TMO_W'(1);
                end
                S_WAIT: if (tx_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_can_frame_builder.sv
// tb_can_frame_builder: directed checks of frame layout, CRC, latency and handshake.
module tb_can_frame_builder;
    logic         GCLK = 1'b0;
    logic         RES;
    logic         frame_go;
    logic [10:0]  id;
    logic [3:0]   dlc;
    logic         rtr;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic [107:0] frame_out;
    logic         tx_start;
    logic         tx_ready;
    logic         busy;
    logic         done;
    logic         err;

    int n_pass = 0;
    int n_tot  = 0;

    can_frame_builder dut (
        .GCLK       (GCLK),
        .RES        (RES),
        .frame_go   (frame_go),
        .id         (id),
        .dlc        (dlc),
        .rtr        (rtr),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .frame_out  (frame_out),
        .tx_start   (tx_start),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 GCLK = ~GCLK;

    task automatic tick();
        @(posedge GCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [107:0] obs, input logic [107:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [107:0] model_frame(input logic [10:0] fid, input logic [3:0] fdlc,
                                                 input logic frtr, input logic [63:0] fdata);
        logic [107:0] f;
        logic [18:0]  h;
        logic [14:0]  c;
        logic         nb;
        int           n;
        int           p;
        f = '1;
        c = '0;
        h = {1'b0, fid, frtr, 1'b0, 1'b0, fdlc};
        if (frtr) n = 0;
        else if (fdlc > 4'd8) n = 8;
        else n = int'(fdlc);
        p = 107;
        for (int i = 18; i >= 0; i--) begin f[p] = h[i]; p--; end
        for (int i = 0; i < 8 * n; i++) begin f[p] = fdata[63 - i]; p--; end
        for (int j = 107; j > p; j--) begin
            nb = f[j] ^ c[14];
            c  = {c[13:0], 1'b0};
            if (nb) c = c ^ 15'h4599;
        end
        for (int i = 14; i >= 0; i--) begin f[p] = c[i]; p--; end
        return f;
    endfunction

    task automatic start(input logic [10:0] fid, input logic [3:0] fdlc, input logic frtr);
        id = fid; dlc = fdlc; rtr = frtr; frame_go = 1'b1;
        tick();
        frame_go = 1'b0;
    endtask

    task automatic wait_tx(output int c);
        c = 0;
        while (!tx_start && c < 2000) begin tick(); c++; end
    endtask

    task automatic handshake(input string tag);
        tick();
        chk({tag, "_wait_txs"}, tx_start, 1);
        chk({tag, "_wait_done0"}, done, 0);
        tx_ready = 1'b1;
        #1;
        chk({tag, "_done"}, done, 1);
        tick();
        chk({tag, "_done_end"}, done, 0);
        chk({tag, "_txs_end"}, tx_start, 0);
        chk({tag, "_busy_end"}, busy, 0);
        tx_ready = 1'b0;
    endtask

    initial begin
        int c;
        logic [107:0] exp_f;
        RES = 1'b1; frame_go = 0; id = 0; dlc = 0; rtr = 0;
        byte_in = 0; byte_valid = 0; tx_ready = 0;
        tick(); tick();
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_frame", frame_out, {108{1'b1}});
        RES = 1'b0;
        tick();

        // id 0x123, dlc 0; a second frame_go while busy must be ignored
        start(11'h123, 4'd0, 1'b0);
        chk("t1_busy", busy, 1);
        id = 11'h3FF; frame_go = 1'b1;
        tick();
        frame_go = 1'b0;
        wait_tx(c);
        chk("t1_latency", 2 + c, 21);
        exp_f = model_frame(11'h123, 4'd0, 1'b0, 64'h0);
        chk("t1_hdr", frame_out[107:89], {1'b0, 11'h123, 1'b0, 1'b0, 1'b0, 4'h0});
        chk("t1_crc", frame_out[88:74], exp_f[88:74]);
        chk("t1_tail", frame_out[73:0], {74{1'b1}});
        handshake("t1");

        // id 0x7FF, dlc 8, back-to-back bytes
        start(11'h7FF, 4'd8, 1'b0);
        byte_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            byte_in = 8'(i + 1);
            chk("t2_ready", byte_ready, 1);
            tick();
        end
        byte_valid = 1'b0;
        chk("t2_ready_drop", byte_ready, 0);
        wait_tx(c);
        chk("t2_latency", 9 + c, 93);
        exp_f = model_frame(11'h7FF, 4'd8, 1'b0, 64'h0102030405060708);
        chk("t2_data", frame_out[88:25], 64'h0102030405060708);
        chk("t2_crc", frame_out[24:10], exp_f[24:10]);
        chk("t2_tail", frame_out[9:0], 10'h3FF);
        chk("t2_frame", frame_out, exp_f);
        handshake("t2");

        // remote frame, dlc 4: no bytes taken even with byte_valid high
        byte_valid = 1'b1; byte_in = 8'hEE;
        start(11'h1A5, 4'd4, 1'b1);
        chk("t3_no_ready", byte_ready, 0);
        wait_tx(c);
        byte_valid = 1'b0;
        chk("t3_latency", 1 + c, 21);
        chk("t3_dlc", frame_out[92:89], 4'b0100);
        chk("t3_frame", frame_out, model_frame(11'h1A5, 4'd4, 1'b1, 64'h0));
        handshake("t3");

        // dlc 12 with a gap before every byte
        start(11'h7FF, 4'd12, 1'b0);
        for (int i = 0; i < 8; i++) begin
            byte_valid = 1'b0;
            tick();
            byte_valid = 1'b1; byte_in = 8'(i + 1);
            tick();
        end
        byte_valid = 1'b0;
        chk("t4_ready_drop", byte_ready, 0);
        wait_tx(c);
        chk("t4_dlc", frame_out[92:89], 4'b1100);
        chk("t4_data", frame_out[88:25], 64'h0102030405060708);
        chk("t4_frame", frame_out, model_frame(11'h7FF, 4'd12, 1'b0, 64'h0102030405060708));
        handshake("t4");

        // tx_ready stuck high: timeout error after 1024 cycles in SEND
        tx_ready = 1'b1;
        start(11'h2A5, 4'd0, 1'b0);
        wait_tx(c);
        chk("t5_latency", 1 + c, 21);
        c = 1;
        while (!err && c < 2000) begin tick(); c++; end
        chk("t5_tmo_cycles", c, 1024);
        chk("t5_txs_at_err", tx_start, 1);
        tick();
        chk("t5_err_end", err, 0);
        chk("t5_txs_end", tx_start, 0);
        chk("t5_busy_end", busy, 0);
        tx_ready = 1'b0;

        // reset in CALC discards the frame
        start(11'h100, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        #2 RES = 1'b1;
        #1;
        chk("t6_rst_txs", tx_start, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_frame", frame_out, {108{1'b1}});
        tick();
        chk("t6_rst_txs_hold", tx_start, 0);
        RES = 1'b0;
        tick();

        // new frame with stale tx_ready high on entry to SEND
        tx_ready = 1'b1;
        start(11'h055, 4'd1, 1'b0);
        byte_valid = 1'b1; byte_in = 8'hAA;
        tick();
        byte_valid = 1'b0;
        wait_tx(c);
        chk("t6_latency", 2 + c, 30);
        exp_f = model_frame(11'h055, 4'd1, 1'b0, {8'hAA, 56'h0});
        chk("t6_frame", frame_out, exp_f);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_stale_done", done, 0);
            chk("t6_stale_txs", tx_start, 1);
        end
        tx_ready = 1'b0;
        tick();
        chk("t6_wait_done0", done, 0);
        tx_ready = 1'b1;
        id = 11'h3FF; frame_go = 1'b1;
        #1;
        chk("t6_done", done, 1);
        tick();
        frame_go = 1'b0;
        chk("t6_go_ignored", busy, 0);
        chk("t6_done_once", done, 0);
        chk("t6_txs_end", tx_start, 0);
        chk("t6_frame_hold", frame_out, exp_f);
        tx_ready = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
